// File: rtl/ysyx_210544_csrfile.sv
// Machine-mode CSR file with an exception-unit port and an execute-stage port.
// Owns mcycle/minstret, samples the CLINT timer line and flags the timer interrupt.
module ysyx_210544_csrfile #(
    parameter logic [63:0] MISA_VALUE = 64'h8000_0000_0000_1100,
    parameter logic [63:0] HARTID     = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] i_exc_addr,
    input  logic        i_exc_ren,
    input  logic        i_exc_wen,
    input  logic [63:0] i_exc_wdata,
    output logic [63:0] o_exc_rdata,
    input  logic [11:0] i_ins_addr,
    input  logic        i_ins_ren,
    input  logic        i_ins_wen,
    input  logic [63:0] i_ins_wdata,
    output logic [63:0] o_ins_rdata,
    input  logic        i_instr_retired,
    input  logic        i_mtip,
    output logic        o_irq_pending,
    output logic        o_illegal
);

    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMisa     = 12'h301;
    localparam logic [11:0] AddrMie      = 12'h304;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMscratch = 12'h340;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;
    localparam logic [11:0] AddrMip      = 12'h344;
    localparam logic [11:0] AddrMcycle   = 12'hB00;
    localparam logic [11:0] AddrMinstret = 12'hB02;
    localparam logic [11:0] AddrMhartid  = 12'hF14;

    localparam logic [63:0] MstatusMask = 64'h1888;
    localparam logic [63:0] MieMask     = 64'h80;

    logic [63:0] mstatus_q, mstatus_d;
    logic [63:0] mie_q, mie_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] mip_q, mip_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic        irq_q;
    logic        illegal_q;

    // Port 0 is the instruction port, port 1 the exception port; later ports override.
    logic [11:0] p_addr  [2];
    logic [63:0] p_wdata [2];
    logic [63:0] p_val   [2];
    logic [1:0]  p_ren, p_wen, p_known, p_ill, p_we;

    assign p_addr[0]  = i_ins_addr;
    assign p_addr[1]  = i_exc_addr;
    assign p_wdata[0] = i_ins_wdata;
    assign p_wdata[1] = i_exc_wdata;
    assign p_ren      = {i_exc_ren, i_ins_ren};
    assign p_wen      = {i_exc_wen, i_ins_wen};

    always_comb begin
        p_known = '1;
        p_ill   = '0;
        p_we    = '0;
        for (int p = 0; p < 2; p++) begin
            p_val[p] = '0;
            case (p_addr[p])
                AddrMstatus:  p_val[p] = mstatus_q;
                AddrMisa:     p_val[p] = MISA_VALUE;
                AddrMie:      p_val[p] = mie_q;
                AddrMtvec:    p_val[p] = mtvec_q;
                AddrMscratch: p_val[p] = mscratch_q;
                AddrMepc:     p_val[p] = mepc_q;
                AddrMcause:   p_val[p] = mcause_q;
                AddrMip:      p_val[p] = mip_q;
                AddrMcycle:   p_val[p] = mcycle_q;
                AddrMinstret: p_val[p] = minstret_q;
                AddrMhartid:  p_val[p] = HARTID;
                default:      p_known[p] = 1'b0;
            endcase
            p_ill[p] = (~p_known[p] & (p_ren[p] | p_wen[p]))
                     | (p_wen[p] & (p_addr[p] == AddrMhartid));
            p_we[p]  = p_wen[p] & ~p_ill[p];
        end
    end

    assign o_ins_rdata = (p_ren[0] & ~p_ill[0]) ? p_val[0] : '0;
    assign o_exc_rdata = (p_ren[1] & ~p_ill[1]) ? p_val[1] : '0;

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mip_d      = {56'd0, i_mtip, 7'd0};
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, i_instr_retired};
        // Exception port is applied last so it wins a same-address collision.
        for (int p = 0; p < 2; p++) begin
            if (p_we[p]) begin
                case (p_addr[p])
                    AddrMstatus:  mstatus_d  = p_wdata[p] & MstatusMask;
                    AddrMie:      mie_d      = p_wdata[p] & MieMask;
                    AddrMtvec:    mtvec_d    = p_wdata[p] & ~64'h2;
                    AddrMscratch: mscratch_d = p_wdata[p];
                    AddrMepc:     mepc_d     = p_wdata[p] & ~64'h1;
                    AddrMcause:   mcause_d   = p_wdata[p];
                    AddrMcycle:   mcycle_d   = p_wdata[p];
                    AddrMinstret: minstret_d = p_wdata[p];
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= 64'h1800;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mip_q      <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            irq_q      <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mip_q      <= mip_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            irq_q      <= mstatus_q[3] & mie_q[7] & mip_q[7];
            illegal_q  <= |p_ill;
        end
    end

    assign o_irq_pending = irq_q;
    assign o_illegal     = illegal_q;

endmodule

// File: tb/tb_ysyx_210544_csrfile.sv
// Bench for ysyx_210544_csrfile: directed scenarios plus random traffic,
// checked against a CSR-space memory model.
module tb_ysyx_210544_csrfile;

    localparam logic [63:0] MISA = 64'h8000_0000_0000_1100;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] i_exc_addr, i_ins_addr;
    logic        i_exc_ren, i_exc_wen, i_ins_ren, i_ins_wen;
    logic [63:0] i_exc_wdata, i_ins_wdata, o_exc_rdata, o_ins_rdata;
    logic        i_instr_retired, i_mtip, o_irq_pending, o_illegal;

    always #5 clk = ~clk;

    ysyx_210544_csrfile dut (
        .clk             (clk),
        .rst             (rst),
        .i_exc_addr      (i_exc_addr),
        .i_exc_ren       (i_exc_ren),
        .i_exc_wen       (i_exc_wen),
        .i_exc_wdata     (i_exc_wdata),
        .o_exc_rdata     (o_exc_rdata),
        .i_ins_addr      (i_ins_addr),
        .i_ins_ren       (i_ins_ren),
        .i_ins_wen       (i_ins_wen),
        .i_ins_wdata     (i_ins_wdata),
        .o_ins_rdata     (o_ins_rdata),
        .i_instr_retired (i_instr_retired),
        .i_mtip          (i_mtip),
        .o_irq_pending   (o_irq_pending),
        .o_illegal       (o_illegal)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Whole 4K CSR space as a memory; only implemented addresses are ever read back.
    logic [63:0] st [0:4095];
    logic        exp_irq, exp_ill;
    logic [11:0] addrs [0:13] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h344, 12'hB00, 12'hB02, 12'hF14, 12'h7C0,
                                  12'h343, 12'h000};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic implemented(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h344, 12'hB00, 12'hB02, 12'hF14};
    endfunction

    function automatic logic is_illegal(input logic [11:0] a, input logic ren, input logic wen);
        return ((ren || wen) && !implemented(a)) || (wen && a == 12'hF14);
    endfunction

    function automatic logic stores_writes(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB02};
    endfunction

    function automatic logic [63:0] store_mask(input logic [11:0] a);
        case (a)
            12'h300: return 64'h1888;
            12'h304: return 64'h80;
            12'h305: return ~64'h2;
            12'h341: return ~64'h1;
            default: return '1;
        endcase
    endfunction

    function automatic logic [63:0] model_read(input logic [11:0] a);
        case (a)
            12'h301: return MISA;
            12'hF14: return 64'd0;
            default: return st[a];
        endcase
    endfunction

    task automatic model_reset();
        foreach (addrs[k]) st[addrs[k]] = 64'd0;
        st[12'h300] = 64'h1800;
        exp_irq = 1'b0;
        exp_ill = 1'b0;
    endtask

    // Inputs are set by the caller; checks reads, clocks once, updates model, checks flags.
    task automatic step(input string tag);
        logic [11:0] ea, ia;
        logic [63:0] e_val, i_val, cyc_n, ret_n, mip_n;
        logic        e_we, i_we, ill_n, irq_n, rst_now;
        #1;
        ea = i_exc_addr;
        ia = i_ins_addr;
        check_eq({tag, "/exc_rdata"}, o_exc_rdata,
                 (i_exc_ren && !is_illegal(ea, i_exc_ren, i_exc_wen)) ? model_read(ea) : 64'd0);
        check_eq({tag, "/ins_rdata"}, o_ins_rdata,
                 (i_ins_ren && !is_illegal(ia, i_ins_ren, i_ins_wen)) ? model_read(ia) : 64'd0);
        ill_n = is_illegal(ea, i_exc_ren, i_exc_wen) || is_illegal(ia, i_ins_ren, i_ins_wen);
        irq_n = st[12'h300][3] & st[12'h304][7] & st[12'h344][7];
        cyc_n = st[12'hB00] + 64'd1;
        ret_n = st[12'hB02] + {63'd0, i_instr_retired};
        mip_n = {56'd0, i_mtip, 7'd0};
        e_we  = i_exc_wen && !is_illegal(ea, i_exc_ren, i_exc_wen) && stores_writes(ea);
        i_we  = i_ins_wen && !is_illegal(ia, i_ins_ren, i_ins_wen) && stores_writes(ia)
                && !(e_we && ia == ea);
        e_val = i_exc_wdata & store_mask(ea);
        i_val = i_ins_wdata & store_mask(ia);
        rst_now = rst;
        @(posedge clk);
        #1;
        if (rst_now) begin
            model_reset();
        end else begin
            st[12'hB00] = cyc_n;
            st[12'hB02] = ret_n;
            st[12'h344] = mip_n;
            if (i_we) st[ia] = i_val;
            if (e_we) st[ea] = e_val;
            exp_irq = irq_n;
            exp_ill = ill_n;
        end
        check_eq({tag, "/irq"}, o_irq_pending, exp_irq);
        check_eq({tag, "/illegal"}, o_illegal, exp_ill);
    endtask

    task automatic idle();
        rst = 1'b0;
        i_exc_ren = 1'b0; i_exc_wen = 1'b0; i_exc_addr = 12'h0; i_exc_wdata = 64'd0;
        i_ins_ren = 1'b0; i_ins_wen = 1'b0; i_ins_addr = 12'h0; i_ins_wdata = 64'd0;
        i_instr_retired = 1'b0;
    endtask

    task automatic exc_wr(input string tag, input logic [11:0] a, input logic [63:0] d);
        idle();
        i_exc_addr = a; i_exc_wen = 1'b1; i_exc_wdata = d;
        step(tag);
    endtask

    task automatic rd_check(input string tag, input logic [11:0] a, input logic [63:0] exp);
        idle();
        i_exc_addr = a; i_exc_ren = 1'b1;
        #1;
        check_eq(tag, o_exc_rdata, exp);
        step(tag);
    endtask

    initial begin
        logic [63:0] c0;
        i_mtip = 1'b0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        step("reset2");

        // Reset values on both ports
        idle();
        i_exc_addr = 12'h300; i_exc_ren = 1'b1;
        i_ins_addr = 12'h305; i_ins_ren = 1'b1;
        #1;
        check_eq("rst_mstatus", o_exc_rdata, 64'h1800);
        check_eq("rst_mtvec", o_ins_rdata, 64'd0);
        check_eq("rst_illegal", o_illegal, 1'b0);
        step("rst_rd");
        idle();
        i_exc_addr = 12'h301; i_exc_ren = 1'b1;
        i_ins_addr = 12'hB00; i_ins_ren = 1'b1;
        #1;
        check_eq("rst_misa", o_exc_rdata, MISA);
        c0 = o_ins_rdata;
        step("misa_rd");
        i_exc_ren = 1'b0;
        #1;
        check_eq("mcycle_inc1", o_ins_rdata, c0 + 64'd1);
        step("mcycle1");
        #1;
        check_eq("mcycle_inc2", o_ins_rdata, c0 + 64'd2);
        step("mcycle2");

        // Write masking on the exception port
        exc_wr("wr_mepc", 12'h341, 64'h8000_0123);
        rd_check("mepc_bit0", 12'h341, 64'h8000_0122);
        exc_wr("wr_mcause", 12'h342, 64'h8000_0000_0000_0007);
        rd_check("mcause_exact", 12'h342, 64'h8000_0000_0000_0007);
        exc_wr("wr_mstatus", 12'h300, '1);
        rd_check("mstatus_mask", 12'h300, 64'h1888);

        // Port collisions
        idle();
        i_exc_addr = 12'h340; i_exc_wen = 1'b1; i_exc_wdata = 64'hA;
        i_ins_addr = 12'h340; i_ins_wen = 1'b1; i_ins_wdata = 64'hB;
        step("same_addr");
        rd_check("exc_wins", 12'h340, 64'hA);
        idle();
        i_exc_addr = 12'h340; i_exc_wen = 1'b1; i_exc_wdata = 64'h1;
        i_ins_addr = 12'h341; i_ins_wen = 1'b1; i_ins_wdata = 64'h8;
        step("diff_addr");
        rd_check("both_mscratch", 12'h340, 64'h1);
        rd_check("both_mepc", 12'h341, 64'h8);

        // Counters
        exc_wr("wr_mcycle", 12'hB00, '1);
        idle();
        step("mcycle_wrap_idle");
        rd_check("mcycle_wrap", 12'hB00, 64'd0);
        exc_wr("clr_minstret", 12'hB02, 64'd0);
        for (int k = 0; k < 3; k++) begin
            idle();
            i_instr_retired = 1'b1;
            step("retire");
        end
        rd_check("minstret_3", 12'hB02, 64'd3);
        idle();
        i_exc_addr = 12'hB02; i_exc_wen = 1'b1; i_exc_wdata = 64'd10; i_instr_retired = 1'b1;
        step("minstret_wr_ret");
        rd_check("minstret_wr_wins", 12'hB02, 64'd10);

        // Timer interrupt path
        exc_wr("wr_mie", 12'h304, 64'h80);
        exc_wr("wr_mie_glob", 12'h300, 64'h8);
        idle();
        i_mtip = 1'b1;
        step("mtip_rise");
        check_eq("irq_not_yet", o_irq_pending, 1'b0);
        step("mtip_hold");
        check_eq("irq_set", o_irq_pending, 1'b1);
        exc_wr("clr_mie_glob", 12'h300, 64'h0);
        check_eq("irq_still", o_irq_pending, 1'b1);
        idle();
        step("irq_drop");
        check_eq("irq_dropped", o_irq_pending, 1'b0);
        i_mtip = 1'b0;

        // Illegal accesses
        rd_check("ill_rdata", 12'h7C0, 64'd0);
        check_eq("ill_pulse", o_illegal, 1'b1);
        idle();
        step("ill_after");
        check_eq("ill_cleared", o_illegal, 1'b0);
        exc_wr("wr_mhartid", 12'hF14, 64'h5);
        check_eq("mhartid_pulse", o_illegal, 1'b1);
        rd_check("mhartid_val", 12'hF14, 64'd0);
        exc_wr("wr_misa", 12'h301, 64'd0);
        check_eq("misa_no_pulse", o_illegal, 1'b0);
        rd_check("misa_kept", 12'h301, MISA);

        // Reset discards a same-cycle write
        idle();
        rst = 1'b1;
        i_exc_addr = 12'h340; i_exc_wen = 1'b1; i_exc_wdata = 64'h55;
        step("rst_with_wr");
        rd_check("rst_discard", 12'h340, 64'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            i_exc_addr  = addrs[$urandom_range(0, 13)];
            i_exc_ren   = 1'($urandom_range(0, 1));
            i_exc_wen   = ($urandom_range(0, 2) == 0);
            i_exc_wdata = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            i_ins_addr  = ($urandom_range(0, 3) == 0) ? i_exc_addr
                                                      : addrs[$urandom_range(0, 13)];
            i_ins_ren   = 1'($urandom_range(0, 1));
            i_ins_wen   = ($urandom_range(0, 2) == 0);
            i_ins_wdata = {$urandom, $urandom};
            i_instr_retired = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) i_mtip = ~i_mtip;
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_210544_csrfile.md
Name: ysyx_210544_csrfile

Overview:
- Machine-mode CSR register file. It is the direct downstream consumer of the exception unit's CSR access bus (addr/ren/wen/wdata) and returns read data to it.
- A second access port serves the execute stage (CSRRW/CSRRS/CSRRC already resolved to a full write value).
- It owns the mcycle/minstret counters, latches the timer-pending bit, and raises the interrupt-pending condition that starts an exception-unit entry sequence.

Parameters:
- MISA_VALUE, 64'h8000_0000_0000_1100, constant misa read value (RV64, I and M).
- HARTID, 64'd0, constant mhartid read value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_exc_addr  in  12  exception-port CSR address
- i_exc_ren  in  1  exception-port read enable
- i_exc_wen  in  1  exception-port write enable
- i_exc_wdata  in  64  exception-port write data
- o_exc_rdata  out  64  exception-port read data
- i_ins_addr  in  12  instruction-port CSR address
- i_ins_ren  in  1  instruction-port read enable
- i_ins_wen  in  1  instruction-port write enable
- i_ins_wdata  in  64  instruction-port write data (final value)
- o_ins_rdata  out  64  instruction-port read data
- i_instr_retired  in  1  one-cycle pulse per retired instruction
- i_mtip  in  1  machine timer interrupt level from the CLINT
- o_irq_pending  out  1  mstatus.MIE & mie.MTIE & mip.MTIP, registered
- o_illegal  out  1  one-cycle pulse flagging an illegal access

Behaviour:
- Reset (rst high at a posedge):
  - mstatus = 64'h1800 (MPP=11).
  - mie, mtvec, mscratch, mepc, mcause, mip, mcycle, minstret = 0.
  - o_irq_pending = 0 and o_illegal = 0.
- rst asserted mid-sequence discards any same-cycle write.
- Read path:
  - Combinational: rdata = selected CSR when ren=1, else 64'h0.
  - Data is valid in the same cycle ren is high, so the exception unit can sample it on the following edge.
  - A read returns the pre-edge value; a write in the same cycle takes effect at the edge.
- Write path: the write commits at the posedge where wen=1.
- Both ports writing the same address in the same cycle: the exception-port write wins and the instruction-port write is dropped.
- Both ports writing different addresses: both writes commit.
- Address map and write rules:
  - 0x300 mstatus: write mask 64'h1888 (MIE[3], MPIE[7], MPP[12:11]). All other bits read 0. The MPP write value is stored as written.
  - 0x301 misa: reads MISA_VALUE. Writes are silently ignored (WARL, not illegal).
  - 0x304 mie: only MTIE[7] is writable; other bits read 0.
  - 0x305 mtvec: bit[1] is forced to 0 on write; all other bits are stored.
  - 0x340 mscratch: full 64-bit.
  - 0x341 mepc: bit[0] is forced to 0 on write.
  - 0x342 mcause: full 64-bit.
  - 0x344 mip: MTIP[7] = i_mtip registered every cycle. Writes are ignored (not illegal).
  - 0xB00 mcycle: increments by 1 every non-reset cycle and wraps from 2^64-1 to 0. A write in the same cycle loads wdata (no increment that cycle).
  - 0xB02 minstret: +1 on each i_instr_retired pulse, with the same write-wins rule and wrap.
  - 0xF14 mhartid: reads HARTID. A write is illegal.
- Illegal accesses:
  - Any other address with ren or wen, or a write to mhartid, gives read data 0 and no state change.
  - o_illegal goes high for exactly the following cycle (registered OR of both ports).
- o_irq_pending is recomputed each cycle from the registered values, so its latency is 1 cycle after the contributing register updates.
  - Example: i_mtip rising at edge N gives mip.MTIP=1 at N and o_irq_pending=1 at N+1, provided MIE and MTIE are set.

Test Plan:
- Reset then read both ports: mstatus reads 64'h1800, mtvec reads 0, misa reads 64'h8000_0000_0000_1100, mcycle counts 1,2,3 on successive reads; o_illegal=0.
- Exception-port sequence: write mepc=64'h8000_0123 → reads 64'h8000_0122. Write mcause=64'h8000_0000_0000_0007 → readback is exact. Write mstatus=64'hFFFF_FFFF_FFFF_FFFF → reads 64'h1888.
- Same-cycle write to 0x340: exc wdata=64'hA, ins wdata=64'hB → mscratch=64'hA. Different addresses (mscratch=1, mepc=8) → both commit.
- Counters: write mcycle=64'hFFFF_FFFF_FFFF_FFFF, then idle one cycle → reads 0. Three i_instr_retired pulses → minstret=3. Pulse coinciding with a minstret write of 64'd10 → 10.
- Interrupt: write mie=64'h80 and mstatus=64'h8, then raise i_mtip → o_irq_pending=1 two edges later. Clear mstatus.MIE → o_irq_pending drops one edge after the write.
- Illegal: read 0x7C0 → rdata 0 and o_illegal pulses one cycle. Write mhartid → value unchanged and o_illegal pulses. Write misa → no pulse.
